// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) arbiter in front of a shared
// single-port memory. One transaction outstanding at a time; requests are
// muxed combinationally, responses are steered back with zero latency, and
// a BUSY watchdog aborts a transaction the memory never answers.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction port
  output logic            imem_req_ready,
  input  logic            imem_req_valid,
  input  logic [XLEN-1:0] imem_req_addr,
  input  logic [2:0]      imem_req_typ,
  output logic            imem_resp_valid,
  output logic [XLEN-1:0] imem_resp_data,
  // data port
  output logic            dmem_req_ready,
  input  logic            dmem_req_valid,
  input  logic [XLEN-1:0] dmem_req_addr,
  input  logic [XLEN-1:0] dmem_req_data,
  input  logic            dmem_req_fcn,
  input  logic [2:0]      dmem_req_typ,
  output logic            dmem_resp_valid,
  output logic [XLEN-1:0] dmem_resp_data,
  // shared memory
  input  logic            mem_req_ready,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_data,
  output logic            mem_req_fcn,
  output logic [2:0]      mem_req_typ,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            arb_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Counter only has to reach TIMEOUT-1, so it never wraps.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;          // 0 imem, 1 dmem
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic grant_dmem;
  logic req_fire;

  // Grantee selection: sole requester wins, a tie goes away from last_grant.
  always_comb begin
    grant_dmem = dmem_req_valid && (!imem_req_valid || !last_grant_q);
  end

  // Request mux from the grantee; imem never writes, so fcn/data are forced 0.
  always_comb begin
    if (grant_dmem) begin
      mem_req_addr = dmem_req_addr;
      mem_req_data = dmem_req_data;
      mem_req_fcn  = dmem_req_fcn;
      mem_req_typ  = dmem_req_typ;
    end else begin
      mem_req_addr = imem_req_addr;
      mem_req_data = '0;
      mem_req_fcn  = 1'b0;
      mem_req_typ  = imem_req_typ;
    end
  end

  // Next-state and handshake/response outputs of the IDLE/BUSY FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a value held and infer a latch.
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    mem_req_valid   = 1'b0;
    imem_req_ready  = 1'b0;
    dmem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    dmem_resp_valid = 1'b0;
    arb_err         = 1'b0;
    req_fire        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A response arriving here belongs to nobody and is dropped.
        mem_req_valid  = grant_dmem ? dmem_req_valid : imem_req_valid;
        imem_req_ready = !grant_dmem && mem_req_ready;
        dmem_req_ready = grant_dmem && mem_req_ready;
        req_fire       = mem_req_valid && mem_req_ready;
        if (req_fire) begin
          state_d      = BUSY;
          owner_d      = grant_dmem;
          last_grant_d = grant_dmem;
          cnt_d        = '0;
        end
      end
      BUSY: begin
        // A response in the timeout cycle still wins over the abort.
        if (mem_resp_valid) begin
          imem_resp_valid = !owner_q;
          dmem_resp_valid = owner_q;
          state_d         = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          arb_err = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status pulses stay low while reset is asserted.
    if (!rst_n) begin
      imem_resp_valid = 1'b0;
      dmem_resp_valid = 1'b0;
      arb_err         = 1'b0;
    end
  end

  // Response data is broadcast; only the valids are steered.
  assign imem_resp_data = mem_resp_data;
  assign dmem_resp_data = mem_resp_data;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard. Stimulus pushes the
// expected accepts, responses and timeout pulses into queues; a negedge
// monitor pops and compares whenever the DUT shows one of those events.
module tb_mem_arbiter;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req_ready, imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic [2:0]      imem_req_typ;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            dmem_req_ready, dmem_req_valid;
  logic [XLEN-1:0] dmem_req_addr, dmem_req_data;
  logic            dmem_req_fcn;
  logic [2:0]      dmem_req_typ;
  logic            dmem_resp_valid;
  logic [XLEN-1:0] dmem_resp_data;
  logic            mem_req_ready, mem_req_valid;
  logic [XLEN-1:0] mem_req_addr, mem_req_data;
  logic            mem_req_fcn;
  logic [2:0]      mem_req_typ;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            arb_err;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_ready(imem_req_ready), .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr), .imem_req_typ(imem_req_typ),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .dmem_req_ready(dmem_req_ready), .dmem_req_valid(dmem_req_valid),
    .dmem_req_addr(dmem_req_addr), .dmem_req_data(dmem_req_data),
    .dmem_req_fcn(dmem_req_fcn), .dmem_req_typ(dmem_req_typ),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .mem_req_ready(mem_req_ready), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic            dmem;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            fcn;
    logic [2:0]      typ;
  } acc_t;

  typedef struct {
    logic            dmem;
    logic [XLEN-1:0] data;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  int   exp_err[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic push_acc(input logic d, input logic [XLEN-1:0] a, input logic [XLEN-1:0] w,
                          input logic f, input logic [2:0] t);
    acc_t e;
    e.dmem = d; e.addr = a; e.data = w; e.fcn = f; e.typ = t;
    exp_acc.push_back(e);
  endtask

  task automatic push_rsp(input logic d, input logic [XLEN-1:0] w);
    rsp_t e;
    e.dmem = d; e.data = w;
    exp_rsp.push_back(e);
  endtask

  // Monitor: compares every accept, response and timeout against the queues.
  always @(negedge clk) begin
    acc_t a;
    rsp_t r;
    int   c;
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      if (exp_acc.size() == 0) unexpected("accept");
      else begin
        a = exp_acc.pop_front();
        check("acc_dmem_ready", dmem_req_ready, a.dmem);
        check("acc_imem_ready", imem_req_ready, !a.dmem);
        check("acc_addr", mem_req_addr, a.addr);
        check("acc_data", mem_req_data, a.data);
        check("acc_fcn", mem_req_fcn, a.fcn);
        check("acc_typ", mem_req_typ, a.typ);
      end
    end
    if (imem_resp_valid === 1'b1 || dmem_resp_valid === 1'b1) begin
      if (exp_rsp.size() == 0) unexpected("resp");
      else begin
        r = exp_rsp.pop_front();
        check("rsp_dmem_valid", dmem_resp_valid, r.dmem);
        check("rsp_imem_valid", imem_resp_valid, !r.dmem);
        check("rsp_data", r.dmem ? dmem_resp_data : imem_resp_data, r.data);
      end
    end
    if (arb_err === 1'b1) begin
      if (exp_err.size() == 0) unexpected("arb_err");
      else begin
        c = exp_err.pop_front();
        check("arb_err_cycle", cyc, c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_valid = 1'b0; imem_req_addr = '0; imem_req_typ = 3'd0;
    dmem_req_valid = 1'b0; dmem_req_addr = '0; dmem_req_data = '0;
    dmem_req_fcn   = 1'b0; dmem_req_typ  = 3'd0;
    mem_req_ready  = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic order[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int   acc_cyc;

  initial begin
    // Reset with a stray memory response present: nothing may escape.
    rst_n = 1'b0;
    idle_inputs();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hFFFF_FFFF;
    tick();
    tick();
    @(negedge clk);
    check("rst_arb_err", arb_err, 1'b0);
    check("rst_imem_resp_valid", imem_resp_valid, 1'b0);
    check("rst_dmem_resp_valid", dmem_resp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("idle_no_req", mem_req_valid, 1'b0);
    tick();

    // First tie after reset goes to dmem; zero-latency response.
    imem_req_valid = 1'b1; imem_req_addr = 32'h40; imem_req_typ = 3'd2;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h1000; dmem_req_data = '0;
    dmem_req_fcn = 1'b0; dmem_req_typ = 3'd2;
    mem_req_ready = 1'b1;
    push_acc(1'b1, 32'h1000, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("tie_dmem_ready", dmem_req_ready, 1'b1);
    check("tie_imem_ready", imem_req_ready, 1'b0);
    tick();
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    push_rsp(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("busy_no_req", mem_req_valid, 1'b0);
    tick();
    mem_resp_valid = 1'b0;

    // Both held valid, 1-cycle memory: grants alternate D,I,D,I.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      imem_req_valid = 1'b1; imem_req_addr = 32'h400 + 32'(i * 4); imem_req_typ = 3'd3;
      dmem_req_valid = 1'b1; dmem_req_addr = 32'h3000 + 32'(i * 4);
      dmem_req_data = 32'hFFFF_0000 + 32'(i); dmem_req_fcn = 1'b1; dmem_req_typ = 3'd2;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
      if (order[i]) push_acc(1'b1, 32'h3000 + 32'(i * 4), 32'hFFFF_0000 + 32'(i), 1'b1, 3'd2);
      else          push_acc(1'b0, 32'h400 + 32'(i * 4), 32'h0, 1'b0, 3'd3);
      tick();
      mem_resp_valid = 1'b1; mem_resp_data = 32'hC0DE_0000 + 32'(i);
      push_rsp(order[i], 32'hC0DE_0000 + 32'(i));
      @(negedge clk);
      check("rr_busy_no_req", mem_req_valid, 1'b0);
      tick();
    end
    idle_inputs();

    // Stalled memory: request held stable, imem not ready until memory is.
    imem_req_valid = 1'b1; imem_req_addr = 32'h100; imem_req_typ = 3'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_req_valid", mem_req_valid, 1'b1);
      check("stall_addr", mem_req_addr, 32'h100);
      check("stall_imem_ready", imem_req_ready, 1'b0);
      tick();
    end
    mem_req_ready = 1'b1;
    push_acc(1'b0, 32'h100, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("stall_release_ready", imem_req_ready, 1'b1);
    tick();
    imem_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_AAAA;
    push_rsp(1'b0, 32'h5555_AAAA);
    tick();
    mem_resp_valid = 1'b0;

    // Timeout: arb_err exactly TIMEOUT cycles after accept, late response dropped.
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h2400; dmem_req_data = '0;
    dmem_req_fcn = 1'b0; dmem_req_typ = 3'd2; mem_req_ready = 1'b1;
    push_acc(1'b1, 32'h2400, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    acc_cyc = cyc;
    exp_err.push_back(acc_cyc + 4);
    tick();
    dmem_req_valid = 1'b0; mem_req_ready = 1'b0;
    repeat (4) tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0BAD;
    @(negedge clk);
    check("late_dmem_resp", dmem_resp_valid, 1'b0);
    check("late_imem_resp", imem_resp_valid, 1'b0);
    tick();
    mem_resp_valid = 1'b0;

    // Response in the timeout cycle wins over the abort.
    imem_req_valid = 1'b1; imem_req_addr = 32'h500; imem_req_typ = 3'd2; mem_req_ready = 1'b1;
    push_acc(1'b0, 32'h500, 32'h0, 1'b0, 3'd2);
    tick();
    imem_req_valid = 1'b0; mem_req_ready = 1'b0;
    repeat (3) tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h600D_F00D;
    push_rsp(1'b0, 32'h600D_F00D);
    @(negedge clk);
    check("edge_no_arb_err", arb_err, 1'b0);
    tick();
    mem_resp_valid = 1'b0;

    // Reset mid-BUSY abandons the transaction; next tie goes to dmem.
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h2800; dmem_req_data = '0;
    dmem_req_fcn = 1'b0; dmem_req_typ = 3'd2; mem_req_ready = 1'b1;
    push_acc(1'b1, 32'h2800, 32'h0, 1'b0, 3'd2);
    tick();
    dmem_req_valid = 1'b0; mem_req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_dmem_resp", dmem_resp_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
    @(negedge clk);
    check("postrst_dmem_resp", dmem_resp_valid, 1'b0);
    check("postrst_imem_resp", imem_resp_valid, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    imem_req_valid = 1'b1; imem_req_addr = 32'h600; imem_req_typ = 3'd2;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h2C00; mem_req_ready = 1'b1;
    push_acc(1'b1, 32'h2C00, 32'h0, 1'b0, 3'd2);
    @(negedge clk);
    check("postrst_tie_dmem", dmem_req_ready, 1'b1);
    tick();
    imem_req_valid = 1'b0; dmem_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222;
    push_rsp(1'b1, 32'h1111_2222);
    tick();
    mem_resp_valid = 1'b0;

    // dmem write passes through exactly and completes on ack.
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h2000; dmem_req_data = 32'h1234_5678;
    dmem_req_fcn = 1'b1; dmem_req_typ = 3'd2; mem_req_ready = 1'b1;
    push_acc(1'b1, 32'h2000, 32'h1234_5678, 1'b1, 3'd2);
    @(negedge clk);
    check("wr_fcn", mem_req_fcn, 1'b1);
    check("wr_data", mem_req_data, 32'h1234_5678);
    tick();
    dmem_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0;
    push_rsp(1'b1, 32'h0);
    tick();
    mem_resp_valid = 1'b0;

    repeat (2) tick();
    check("left_accepts", exp_acc.size(), 0);
    check("left_resps", exp_rsp.size(), 0);
    check("left_errs", exp_err.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
